csa_resolve_seq: RTL

Sequential carry-propagate resolver for the multiplier's carry-save tree. It accepts one redundant (sum, carry) vector pair, as produced by a 3:2 compressor stage, and reduces it to a single binary word plus carry-out. It processes one CHUNK-bit slice per cycle, rippling the inter-chunk carry through a register. It sits between the final compressor stage and mantissa normalisation/rounding, with valid/ready handshakes on both sides.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/cpa_chunk.sv | 41 ++++
 rtl/csa_resolve_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared multiplier definitions: resolver FSM states, the default datapath width
// and the chunking helpers used by the carry-propagate resolver.
package mult_pkg;

    localparam int MULT_WIDTH = 33;
    localparam int MULT_CHUNK = 11;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    function automatic int nchunk(input int w, input int c);
        return w / c;
    endfunction

    function automatic bit chunk_ok(input int w, input int c);
        return (c > 0) && (w >= c) && ((w % c) == 0);
    endfunction

endpackage

// File: rtl/cpa_chunk.sv
// CHUNK-bit combinational ripple adder for the carry-save resolver,
// assembled from the full-adder cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module cpa_chunk #(
    parameter int W = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;
    assign cout = c[W];

    for (genvar i = 0; i < W; i++) begin : g_fa
        fa_cell u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

endmodule

// File: rtl/csa_resolve_seq.sv
// Sequential carry-propagate resolver: turns a (sum, carry) pair into a binary
// word plus carry-out, one CHUNK-bit slice per cycle.
module csa_resolve_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CHUNK = MULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_chunk
        $error("csa_resolve_seq: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;

    int               lo;
    logic [CHUNK-1:0] a_k, b_k, s_k;
    logic             c_k;

    assign lo  = int'(idx_q) * CHUNK;
    assign a_k = opa_q[lo +: CHUNK];
    assign b_k = opb_q[lo +: CHUNK];

    cpa_chunk #(
        .W(CHUNK)
    ) u_chunk (
        .a   (a_k),
        .b   (b_k),
        .cin (cy_q),
        .s   (s_k),
        .cout(c_k)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cy_d        = cy_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_d       = res_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = sum_in;
                    opb_d   = carry_in;
                    idx_d   = '0;
                    cy_d    = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                res_d[lo +: CHUNK] = s_k;
                cy_d  = c_k;
                idx_d = idx_q + IDXW'(1);
                if (idx_q == LAST) begin
                    idx_d       = '0;
                    cout_d      = c_k;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cy_q        <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cy_q        <= cy_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            res_q       <= res_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign cout      = cout_q;

endmodule
